// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and default geometry for the SRAM request controller
// and its response FIFO.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 36;
  localparam int SRAM_DEPTH  = 128;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response FIFO holding SRAM read data until the consumer takes it.
// The occupancy count is exported so the controller can do credit accounting.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    // Push and pop in the same cycle leave the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_rw_ctrl.sv
// Request-side controller for the 128x36 single-port masked SRAM (RW0_* port).
// Optional post-reset zero sweep of the array is enabled by SRAM_RESET_INIT_EN.
module sram_rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  if (DEPTH != (1 << ADDR_W)) begin : g_depth_chk
    $error("sram_rw_ctrl: DEPTH must equal 2**ADDR_W");
  end

  logic              run;
  logic              init_active;
  logic [ADDR_W-1:0] sweep_addr;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop;
  logic              req_fire;

`ifdef SRAM_RESET_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + ADDR_W'(1);
      if (sweep_q == LAST_ADDR) state_d = ST_RUN;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign init_active = (state_q == ST_INIT);
  assign sweep_addr  = sweep_q;
`else
  assign run         = 1'b1;
  assign init_active = 1'b0;
  assign sweep_addr  = '0;
`endif

  assign init_done = run;

  // Credit: buffered responses plus the read whose data arrives next cycle.
  assign occ       = {1'b0, count} + {2'b00, rd_pend_q};
  assign pop       = resp_valid && resp_ready;
  assign req_ready = !reset && run && (req_write || (occ < 3'd2) || pop);
  assign req_fire  = req_valid && req_ready;
  assign rd_pend_d = req_fire && !req_write;

  always_ff @(posedge clock) begin
    if (reset) rd_pend_q <= 1'b0;
    else       rd_pend_q <= rd_pend_d;
  end

  always_comb begin
    sram_en    = req_fire;
    sram_wmode = req_write;
    sram_addr  = req_addr;
    sram_wmask = req_wmask;
    sram_wdata = req_wdata;
    if (init_active) begin
      sram_en    = !reset;
      sram_wmode = 1'b1;
      sram_addr  = sweep_addr;
      sram_wmask = '1;
      sram_wdata = '0;
    end
  end

  sram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (rd_pend_q),
    .push_data_i (sram_rdata),
    .pop_i       (pop),
    .valid_o     (resp_valid),
    .data_o      (resp_data),
    .count_o     (count)
  );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Self-checking bench for sram_rw_ctrl with a behavioural masked SRAM model
// and a reference memory feeding an expected-response queue.
module tb_sram_rw_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 36;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wmask = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [DW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] exp_q [$];

  always #5 clock = ~clock;

  sram_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .init_done  (init_done)
  );

  // Masked single-port SRAM: read data is only meaningful the cycle after a read.
  always @(posedge clock) begin
    sram_rdata <= 36'hBAD_5A5A5;
    if (sram_en) begin
      if (sram_wmode)
        sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else
        sram_rdata <= sram_mem[sram_addr];
    end
  end

  // One cycle: drive at negedge, sample just after, update the reference on accept.
  task automatic drive_cycle(input logic v, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] m, input logic [DW-1:0] d, input logic rr,
                             output logic acc, output logic got, output logic [DW-1:0] rd);
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wmask  = m;
    req_wdata  = d;
    resp_ready = rr;
    #1;
    acc = req_valid && req_ready;
    got = resp_valid && resp_ready;
    rd  = resp_data;
    if (acc) begin
      if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      else   exp_q.push_back(ref_mem[a]);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic acc, got;
    logic [DW-1:0] rd;
    reset = 1'b1;
    drive_cycle(1'b1, 1'b1, 7'd0, '1, '0, 1'b0, acc, got, rd);
    drive_cycle(1'b1, 1'b1, 7'd0, '1, '0, 1'b0, acc, got, rd);
    total++; if (acc !== 1'b0) begin bad++; $display("FAIL reset_accept got=%0b want=0", acc); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
    total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL reset_sram_en got=%0b want=0", sram_en); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b want=0", resp_valid); end
`ifdef SRAM_RESET_INIT_EN
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%0b want=0", init_done); end
`else
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL reset_init_done got=%0b want=1", init_done); end
`endif
  endtask

  task automatic test_init();
    logic acc, got;
    logic [DW-1:0] rd;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    #1;
`ifdef SRAM_RESET_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin @(negedge clock); #1; end
      total++;
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== AW'(i) ||
          sram_wmask !== {DW{1'b1}} || sram_wdata !== '0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
        bad++;
        $display("FAIL init_sweep cyc=%0d got en=%0b wm=%0b addr=%0d mask=%h data=%h rdy=%0b done=%0b want en=1 wm=1 addr=%0d mask=all-ones data=0 rdy=0 done=0",
                 i, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, req_ready, init_done, i);
      end
    end
    @(negedge clock); #1;
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_at_128 got=%0b want=1", init_done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL init_ready_at_128 got=%0b want=1", req_ready); end
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    drive_cycle(1'b1, 1'b0, 7'd5, '0, '0, 1'b1, acc, got, rd);
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
      if (got) begin
        total++; if (rd !== 36'h0) begin bad++; $display("FAIL init_read5 got=%h want=0", rd); end
        void'(exp_q.pop_front());
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL init_read5_timeout got=%0d pending want=0", exp_q.size()); end
`else
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_release got=%0b want=1", init_done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_release got=%0b want=1", req_ready); end
    @(negedge clock);
`endif
  endtask

  task automatic test_write_read();
    logic acc, got;
    logic [DW-1:0] rd, exp;
    drive_cycle(1'b1, 1'b1, 7'h10, '1, 36'hABCDE1234, 1'b1, acc, got, rd);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL wr_accept got=%0b want=1", acc); end
    drive_cycle(1'b1, 1'b0, 7'h10, '0, '0, 1'b1, acc, got, rd);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL rd_accept got=%0b want=1", acc); end
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
    total++; if (got !== 1'b0) begin bad++; $display("FAIL rd_latency_t1 got=%0b want=0", got); end
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rd_latency_t2 got=%0b want=1", got); end
    if (got && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++; if (rd !== exp) begin bad++; $display("FAIL wr_rd_data got=%h want=%h", rd, exp); end
      total++; if (rd !== 36'hABCDE1234) begin bad++; $display("FAIL wr_rd_const got=%h want=abcde1234", rd); end
    end
    exp_q.delete();
  endtask

  task automatic test_masked();
    logic acc, got;
    logic [DW-1:0] rd, exp;
    drive_cycle(1'b1, 1'b1, 7'd3, '1, 36'hFFFFFFFFF, 1'b1, acc, got, rd);
    drive_cycle(1'b1, 1'b1, 7'd3, 36'h00000FFFF, 36'h0, 1'b1, acc, got, rd);
    total++; if (sram_mem[3] !== 36'hFFFFF0000 && acc === 1'b1) begin
      bad++; $display("FAIL masked_port got=%h want=fffff0000", sram_mem[3]);
    end
    drive_cycle(1'b1, 1'b0, 7'd3, '0, '0, 1'b1, acc, got, rd);
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
      if (got) begin
        exp = exp_q.pop_front();
        total++; if (rd !== exp) begin bad++; $display("FAIL masked_data got=%h want=%h", rd, exp); end
        total++; if (rd !== 36'hFFFFF0000) begin bad++; $display("FAIL masked_const got=%h want=fffff0000", rd); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL masked_timeout got=%0d pending want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic acc, got;
    logic [DW-1:0] rd, exp;
    int nacc = 0;
    int nresp = 0;
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 1'b1, AW'(20 + i), '1, DW'(36'h111111111 * (i + 1)), 1'b1, acc, got, rd);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, AW'(20 + i), '0, '0, 1'b0, acc, got, rd);
      if (acc) nacc++;
    end
    total++; if (nacc != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", nacc); end
    req_valid = 1'b1; req_write = 1'b0; resp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_read_ready got=%0b want=0", req_ready); end
    @(negedge clock);
    drive_cycle(1'b1, 1'b1, 7'd30, '1, 36'h123456789, 1'b0, acc, got, rd);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_write_accept got=%0b want=1", acc); end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, got, rd);
      total++;
      if (resp_valid !== 1'b1 || exp_q.size() == 0 || resp_data !== exp_q[0]) begin
        bad++; $display("FAIL bp_stable got v=%0b d=%h want v=1 head of %0d expected", resp_valid, resp_data, exp_q.size());
      end
    end
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
      if (got) begin
        exp = exp_q.pop_front();
        nresp++;
        total++; if (rd !== exp) begin bad++; $display("FAIL bp_drain_data got=%h want=%h", rd, exp); end
      end
    end
    total++; if (nresp != 2) begin bad++; $display("FAIL bp_drain_count got=%0d want=2", nresp); end
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", resp_valid); end
    exp_q.delete();
  endtask

  task automatic test_stream();
    logic acc, got;
    logic [DW-1:0] rd, exp;
    logic [63:0] r;
    int issued = 0;
    int nresp = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 64; i++) begin
      r = {$urandom(), $urandom()};
      drive_cycle(1'b1, 1'b1, AW'(i), '1, r[DW-1:0], 1'b1, acc, got, rd);
    end
    for (int c = 0; c < 80 && nresp < 64; c++) begin
      drive_cycle(issued < 64, 1'b0, AW'(issued), '0, '0, 1'b1, acc, got, rd);
      if (acc) issued++;
      if (got) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL stream_unexpected got=%h want=none", rd);
        end else begin
          exp = exp_q.pop_front();
          total++; if (rd !== exp) begin bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", nresp, rd, exp); end
        end
        if (first < 0) first = c;
        last = c;
        nresp++;
      end
    end
    total++; if (issued != 64) begin bad++; $display("FAIL stream_issued got=%0d want=64", issued); end
    total++; if (nresp != 64) begin bad++; $display("FAIL stream_resp got=%0d want=64", nresp); end
    total++; if (last - first != 63) begin bad++; $display("FAIL stream_consecutive got=%0d want=63", last - first); end
    total++; if (first != 2) begin bad++; $display("FAIL stream_first got=%0d want=2", first); end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic acc, got;
    logic [DW-1:0] rd, exp;
    int nresp = 0;
    drive_cycle(1'b1, 1'b0, 7'h10, '0, '0, 1'b0, acc, got, rd);
    drive_cycle(1'b1, 1'b0, 7'd3, '0, '0, 1'b0, acc, got, rd);
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, got, rd);
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, got, rd);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL mr_buffered got=%0b want=1", resp_valid); end
    reset = 1'b1;
    drive_cycle(1'b1, 1'b1, 7'd9, '1, '1, 1'b0, acc, got, rd);
    exp_q.delete();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mr_resp_valid got=%0b want=0", resp_valid); end
    total++; if (sram_en !== 1'b0) begin bad++; $display("FAIL mr_sram_en got=%0b want=0", sram_en); end
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, acc, got, rd);
    reset = 1'b0;
`ifdef SRAM_RESET_INIT_EN
    for (int c = 0; c < 10; c++) drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
    reset = 1'b0;
    #1;
    total++; if (sram_en !== 1'b1 || sram_addr !== '0) begin
      bad++; $display("FAIL mr_sweep_restart got en=%0b addr=%0d want en=1 addr=0", sram_en, sram_addr);
    end
    @(negedge clock);
    for (int c = 0; c < 200 && init_done !== 1'b1; c++) @(negedge clock);
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL mr_init_timeout got=%0b want=1", init_done); end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
      total++; if (got !== 1'b0) begin bad++; $display("FAIL mr_stale cyc=%0d got=%0b want=0", c, got); end
    end
    drive_cycle(1'b1, 1'b0, 7'h10, '0, '0, 1'b1, acc, got, rd);
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc, got, rd);
      if (got) begin
        exp = exp_q.pop_front();
        nresp++;
        total++; if (rd !== exp) begin bad++; $display("FAIL mr_persist got=%h want=%h", rd, exp); end
      end
    end
    total++; if (nresp != 1) begin bad++; $display("FAIL mr_persist_count got=%0d want=1", nresp); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clock);
    test_reset();
    test_init();
    test_write_read();
    test_masked();
    test_backpressure();
    test_stream();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
